pcie_axi_dma_desc_mux_credit: RTL and testbench

//  N-to-1 descriptor mux between PORTS DMA clients and one PCIe AXI DMA core, with per-port

---
 rtl/pcie_axi_dma_desc_mux_credit.sv | 203 ++++++++++++++++++++
 tb/tb_pcie_axi_dma_desc_mux_credit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_axi_dma_desc_mux_credit.sv
// rtl/pcie_axi_dma_desc_mux_credit.sv - credit-gated N-to-1 DMA descriptor mux with registered status demux
// Optional feature macro: PCIE_DMA_DESC_MUX_ERR_CNT_EN adds per-port error counters on err_count.
module pcie_axi_dma_desc_mux_credit #(
  parameter int PORTS           = 2,
  parameter int PCIE_ADDR_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH  = 16,
  parameter int LEN_WIDTH       = 20,
  parameter int S_TAG_WIDTH     = 8,
  parameter int M_TAG_WIDTH     = S_TAG_WIDTH + $clog2(PORTS),
  parameter int OP_COUNT_WIDTH  = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int ARB_ROUND_ROBIN = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  output logic [PCIE_ADDR_WIDTH-1:0]          m_axis_desc_pcie_addr,
  output logic [AXI_ADDR_WIDTH-1:0]           m_axis_desc_axi_addr,
  output logic [LEN_WIDTH-1:0]                m_axis_desc_len,
  output logic [M_TAG_WIDTH-1:0]              m_axis_desc_tag,
  output logic                                m_axis_desc_valid,
  input  logic                                m_axis_desc_ready,
  input  logic [M_TAG_WIDTH-1:0]              s_axis_desc_status_tag,
  input  logic [3:0]                          s_axis_desc_status_error,
  input  logic                                s_axis_desc_status_valid,
  input  logic [PORTS*PCIE_ADDR_WIDTH-1:0]    s_axis_desc_pcie_addr,
  input  logic [PORTS*AXI_ADDR_WIDTH-1:0]     s_axis_desc_axi_addr,
  input  logic [PORTS*LEN_WIDTH-1:0]          s_axis_desc_len,
  input  logic [PORTS*S_TAG_WIDTH-1:0]        s_axis_desc_tag,
  input  logic [PORTS-1:0]                    s_axis_desc_valid,
  output logic [PORTS-1:0]                    s_axis_desc_ready,
  output logic [PORTS*S_TAG_WIDTH-1:0]        m_axis_desc_status_tag,
  output logic [PORTS*4-1:0]                  m_axis_desc_status_error,
  output logic [PORTS-1:0]                    m_axis_desc_status_valid,
`ifdef PCIE_DMA_DESC_MUX_ERR_CNT_EN
  output logic [PORTS*16-1:0]                 err_count,
`endif
  output logic [PORTS*OP_COUNT_WIDTH-1:0]     outstanding_count
);

  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int CW = OP_COUNT_WIDTH;
  localparam int DW = PCIE_ADDR_WIDTH + AXI_ADDR_WIDTH + LEN_WIDTH + M_TAG_WIDTH;

  logic [CW-1:0]          count_q [PORTS];
  logic [CW-1:0]          count_d [PORTS];
  logic [PORTS-1:0]       eligible;
  logic                   grant_valid;
  logic                   found_hi;
  logic [PW-1:0]          grant_idx, hi_idx, lo_idx;
  logic [PW-1:0]          rr_q, rr_d;
  logic                   int_valid;
  logic                   int_ready_q, int_ready_d;
  logic [S_TAG_WIDTH-1:0] sel_tag;
  logic [DW-1:0]          int_data;
  logic [DW-1:0]          out_data_q, out_data_d, tmp_data_q, tmp_data_d;
  logic                   out_valid_q, out_valid_d, tmp_valid_q, tmp_valid_d;
  logic [M_TAG_WIDTH-1:0] st_port;
  logic [PORTS-1:0]       stat_valid_q, stat_valid_d;
  logic [S_TAG_WIDTH-1:0] stat_tag_q;
  logic [3:0]             stat_err_q;

  // RR: prefer the lowest eligible port at or above rr_q, else wrap to the lowest eligible.
  always_comb begin
    eligible    = '0;
    grant_valid = 1'b0;
    found_hi    = 1'b0;
    hi_idx      = '0;
    lo_idx      = '0;
    for (int i = 0; i < PORTS; i++) begin
      eligible[i] = s_axis_desc_valid[i] && (count_q[i] < CW'(MAX_OUTSTANDING));
    end
    for (int i = PORTS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant_valid = 1'b1;
        lo_idx      = PW'(i);
        if (i >= int'(rr_q)) begin
          found_hi = 1'b1;
          hi_idx   = PW'(i);
        end
      end
    end
    grant_idx = (ARB_ROUND_ROBIN != 0 && found_hi) ? hi_idx : lo_idx;
  end

  always_comb begin
    s_axis_desc_ready = '0;
    int_data          = '0;
    sel_tag           = '0;
    int_valid         = grant_valid && int_ready_q;
    for (int i = 0; i < PORTS; i++) begin
      if (grant_idx == PW'(i)) begin
        s_axis_desc_ready[i] = grant_valid && int_ready_q;
        sel_tag              = s_axis_desc_tag[i*S_TAG_WIDTH +: S_TAG_WIDTH];
        int_data[DW-1 -: PCIE_ADDR_WIDTH + AXI_ADDR_WIDTH + LEN_WIDTH] =
          {s_axis_desc_pcie_addr[i*PCIE_ADDR_WIDTH +: PCIE_ADDR_WIDTH],
           s_axis_desc_axi_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH],
           s_axis_desc_len[i*LEN_WIDTH +: LEN_WIDTH]};
      end
    end
    int_data[M_TAG_WIDTH-1:0] = M_TAG_WIDTH'(sel_tag) | (M_TAG_WIDTH'(grant_idx) << S_TAG_WIDTH);
    rr_d = rr_q;
    if (int_valid && ARB_ROUND_ROBIN != 0) begin
      rr_d = (grant_idx == PW'(PORTS - 1)) ? '0 : grant_idx + PW'(1);
    end
  end

  // Two-entry skid: the temp slot absorbs the one accept that lands while the output stalls.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    tmp_valid_d = tmp_valid_q;
    tmp_data_d  = tmp_data_q;
    int_ready_d = m_axis_desc_ready || (!tmp_valid_q && (!out_valid_q || !int_valid));
    if (int_ready_q) begin
      if (m_axis_desc_ready || !out_valid_q) begin
        out_valid_d = int_valid;
        out_data_d  = int_data;
      end else begin
        tmp_valid_d = int_valid;
        tmp_data_d  = int_data;
      end
    end else if (m_axis_desc_ready) begin
      out_valid_d = tmp_valid_q;
      out_data_d  = tmp_data_q;
      tmp_valid_d = 1'b0;
    end
  end

  // Statuses whose port field is out of range match no port and are dropped here.
  always_comb begin
    st_port      = s_axis_desc_status_tag >> S_TAG_WIDTH;
    stat_valid_d = '0;
    for (int i = 0; i < PORTS; i++) begin
      stat_valid_d[i] = s_axis_desc_status_valid && (st_port == M_TAG_WIDTH'(i));
      count_d[i]      = count_q[i];
      if (s_axis_desc_ready[i] && s_axis_desc_valid[i] && !stat_valid_d[i]) begin
        count_d[i] = count_q[i] + CW'(1);
      end else if (stat_valid_d[i] && !(s_axis_desc_ready[i] && s_axis_desc_valid[i]) &&
                   count_q[i] != '0) begin
        count_d[i] = count_q[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q         <= '0;
      int_ready_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      tmp_valid_q  <= 1'b0;
      out_data_q   <= '0;
      tmp_data_q   <= '0;
      stat_valid_q <= '0;
      stat_tag_q   <= '0;
      stat_err_q   <= '0;
      for (int i = 0; i < PORTS; i++) count_q[i] <= '0;
    end else begin
      rr_q         <= rr_d;
      int_ready_q  <= int_ready_d;
      out_valid_q  <= out_valid_d;
      tmp_valid_q  <= tmp_valid_d;
      out_data_q   <= out_data_d;
      tmp_data_q   <= tmp_data_d;
      stat_valid_q <= stat_valid_d;
      stat_tag_q   <= s_axis_desc_status_tag[S_TAG_WIDTH-1:0];
      stat_err_q   <= s_axis_desc_status_error;
      for (int i = 0; i < PORTS; i++) count_q[i] <= count_d[i];
    end
  end

  assign m_axis_desc_valid        = out_valid_q;
  assign {m_axis_desc_pcie_addr, m_axis_desc_axi_addr, m_axis_desc_len, m_axis_desc_tag} = out_data_q;
  assign m_axis_desc_status_valid = stat_valid_q;
  assign m_axis_desc_status_tag   = {PORTS{stat_tag_q}};
  assign m_axis_desc_status_error = {PORTS{stat_err_q}};

  always_comb begin
    outstanding_count = '0;
    for (int i = 0; i < PORTS; i++) outstanding_count[i*CW +: CW] = count_q[i];
  end

`ifdef PCIE_DMA_DESC_MUX_ERR_CNT_EN
  logic [15:0] err_q [PORTS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PORTS; i++) err_q[i] <= '0;
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        if (stat_valid_d[i] && s_axis_desc_status_error != 4'h0 && err_q[i] != 16'hFFFF) begin
          err_q[i] <= err_q[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    err_count = '0;
    for (int i = 0; i < PORTS; i++) err_count[i*16 +: 16] = err_q[i];
  end
`endif

endmodule

// File: tb/tb_pcie_axi_dma_desc_mux_credit.sv
// tb/tb_pcie_axi_dma_desc_mux_credit.sv - directed vector bench for pcie_axi_dma_desc_mux_credit
// Four ports, credit limit 4; err_count checks compile in with PCIE_DMA_DESC_MUX_ERR_CNT_EN.
module tb_pcie_axi_dma_desc_mux_credit;
  localparam int P = 4, PA = 64, AA = 16, LW = 20, ST = 8, MT = 10, CW = 4, MAXO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [PA-1:0]   m_pcie;
  logic [AA-1:0]   m_axi;
  logic [LW-1:0]   m_len;
  logic [MT-1:0]   m_tag;
  logic            m_valid, m_ready;
  logic [MT-1:0]   st_tag;
  logic [3:0]      st_err;
  logic            st_valid;
  logic [P*PA-1:0] s_pcie;
  logic [P*AA-1:0] s_axi;
  logic [P*LW-1:0] s_len;
  logic [P*ST-1:0] s_tag;
  logic [P-1:0]    s_valid, s_ready;
  logic [P*ST-1:0] ms_tag;
  logic [P*4-1:0]  ms_err;
  logic [P-1:0]    ms_valid;
  logic [P*CW-1:0] ocount;
`ifdef PCIE_DMA_DESC_MUX_ERR_CNT_EN
  logic [P*16-1:0] err_count;
`endif

  pcie_axi_dma_desc_mux_credit #(
    .PORTS(P), .PCIE_ADDR_WIDTH(PA), .AXI_ADDR_WIDTH(AA), .LEN_WIDTH(LW),
    .S_TAG_WIDTH(ST), .M_TAG_WIDTH(MT), .OP_COUNT_WIDTH(CW),
    .MAX_OUTSTANDING(MAXO), .ARB_ROUND_ROBIN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_axis_desc_pcie_addr(m_pcie), .m_axis_desc_axi_addr(m_axi),
    .m_axis_desc_len(m_len), .m_axis_desc_tag(m_tag),
    .m_axis_desc_valid(m_valid), .m_axis_desc_ready(m_ready),
    .s_axis_desc_status_tag(st_tag), .s_axis_desc_status_error(st_err),
    .s_axis_desc_status_valid(st_valid),
    .s_axis_desc_pcie_addr(s_pcie), .s_axis_desc_axi_addr(s_axi),
    .s_axis_desc_len(s_len), .s_axis_desc_tag(s_tag),
    .s_axis_desc_valid(s_valid), .s_axis_desc_ready(s_ready),
    .m_axis_desc_status_tag(ms_tag), .m_axis_desc_status_error(ms_err),
    .m_axis_desc_status_valid(ms_valid),
`ifdef PCIE_DMA_DESC_MUX_ERR_CNT_EN
    .err_count(err_count),
`endif
    .outstanding_count(ocount)
  );

  typedef struct {
    logic [3:0]  sv;  logic mr;  logic stv; logic [9:0] stt; logic [3:0] ste;
    logic [3:0]  er;  logic emv; logic [9:0] emt; logic [15:0] ec;
    logic [3:0]  esv; logic [7:0] est; logic [3:0] ese;
  } vec_t;

  typedef struct {
    logic [PA-1:0] pa; logic [AA-1:0] aa; logic [LW-1:0] ln; logic [MT-1:0] tg;
  } desc_t;

  int total = 0;
  int bad   = 0;
  logic [7:0] tag_v [P];
  vec_t  tbl [14];
  desc_t expq [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic desc_t model(input int p, input logic [7:0] t);
    desc_t d;
    d.pa = 64'hDEAD_0000_0000_0000 | (64'(p) << 16) | 64'(t);
    d.aa = 16'h1000 | 16'(p << 8) | 16'(t);
    d.ln = 20'h400 + 20'(t);
    d.tg = 10'(p << 8) | 10'(t);
    return d;
  endfunction

  task automatic drive_fields();
    desc_t d;
    for (int i = 0; i < P; i++) begin
      d = model(i, tag_v[i]);
      s_pcie[i*PA +: PA] = d.pa;
      s_axi[i*AA +: AA]  = d.aa;
      s_len[i*LW +: LW]  = d.ln;
      s_tag[i*ST +: ST]  = tag_v[i];
    end
  endtask

  initial begin
    int n;
    int nout;
    logic [P-1:0] acc;
    logic stall_prev;
    logic [63:0] prev_pa;
    logic [45:0] prev_f;
    desc_t d;

    //        sv     mr    stv   stt     ste    er     emv   emt      ec        esv    est    ese
    tbl[0]  = '{4'hF, 1'b1, 1'b0, 10'h000, 4'h0, 4'h0, 1'b0, 10'h000, 16'h0000, 4'h0, 8'h00, 4'h0};
    tbl[1]  = '{4'hF, 1'b1, 1'b0, 10'h000, 4'h0, 4'h1, 1'b0, 10'h000, 16'h0000, 4'h0, 8'h00, 4'h0};
    tbl[2]  = '{4'hF, 1'b1, 1'b0, 10'h000, 4'h0, 4'h2, 1'b1, 10'h0A0, 16'h0001, 4'h0, 8'h00, 4'h0};
    tbl[3]  = '{4'hF, 1'b1, 1'b0, 10'h000, 4'h0, 4'h4, 1'b1, 10'h1A1, 16'h0011, 4'h0, 8'h00, 4'h0};
    tbl[4]  = '{4'hF, 1'b1, 1'b0, 10'h000, 4'h0, 4'h8, 1'b1, 10'h2A2, 16'h0111, 4'h0, 8'h00, 4'h0};
    tbl[5]  = '{4'hF, 1'b1, 1'b0, 10'h000, 4'h0, 4'h1, 1'b1, 10'h3A3, 16'h1111, 4'h0, 8'h00, 4'h0};
    tbl[6]  = '{4'h0, 1'b1, 1'b0, 10'h000, 4'h0, 4'h0, 1'b1, 10'h0A0, 16'h1112, 4'h0, 8'h00, 4'h0};
    tbl[7]  = '{4'h0, 1'b1, 1'b1, 10'h155, 4'h0, 4'h0, 1'b0, 10'h000, 16'h1112, 4'h0, 8'h00, 4'h0};
    tbl[8]  = '{4'h0, 1'b1, 1'b1, 10'h366, 4'h2, 4'h0, 1'b0, 10'h000, 16'h1102, 4'h2, 8'h55, 4'h0};
    tbl[9]  = '{4'h0, 1'b1, 1'b1, 10'h077, 4'h0, 4'h0, 1'b0, 10'h000, 16'h0102, 4'h8, 8'h66, 4'h2};
    tbl[10] = '{4'h0, 1'b1, 1'b1, 10'h288, 4'h0, 4'h0, 1'b0, 10'h000, 16'h0101, 4'h1, 8'h77, 4'h0};
    tbl[11] = '{4'h0, 1'b1, 1'b1, 10'h200, 4'h3, 4'h0, 1'b0, 10'h000, 16'h0001, 4'h4, 8'h88, 4'h0};
    tbl[12] = '{4'h0, 1'b1, 1'b0, 10'h000, 4'h0, 4'h0, 1'b0, 10'h000, 16'h0001, 4'h4, 8'h00, 4'h3};
    tbl[13] = '{4'h0, 1'b1, 1'b0, 10'h000, 4'h0, 4'h0, 1'b0, 10'h000, 16'h0001, 4'h0, 8'h00, 4'h0};

    for (int i = 0; i < P; i++) tag_v[i] = 8'hA0 + 8'(i);
    drive_fields();
    rst_n = 1'b0; s_valid = 4'hF; m_ready = 1'b1;
    st_valid = 1'b0; st_tag = '0; st_err = '0;

    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      chk("rst_ready", 64'(s_ready), 0);
      chk("rst_mvalid", 64'(m_valid), 0);
      chk("rst_counts", 64'(ocount), 0);
      chk("rst_stvalid", 64'(ms_valid), 0);
    end
    rst_n = 1'b1;

    for (int r = 0; r < 14; r++) begin
      s_valid = tbl[r].sv; m_ready = tbl[r].mr;
      st_valid = tbl[r].stv; st_tag = tbl[r].stt; st_err = tbl[r].ste;
      #1;
      chk($sformatf("row%0d_ready", r), 64'(s_ready), 64'(tbl[r].er));
      chk($sformatf("row%0d_mvalid", r), 64'(m_valid), 64'(tbl[r].emv));
      if (tbl[r].emv) chk($sformatf("row%0d_mtag", r), 64'(m_tag), 64'(tbl[r].emt));
      chk($sformatf("row%0d_counts", r), 64'(ocount), 64'(tbl[r].ec));
      chk($sformatf("row%0d_stvalid", r), 64'(ms_valid), 64'(tbl[r].esv));
      if (tbl[r].esv != 4'h0) begin
        chk($sformatf("row%0d_sttag", r), 64'(ms_tag), 64'({4{tbl[r].est}}));
        chk($sformatf("row%0d_sterr", r), 64'(ms_err), 64'({4{tbl[r].ese}}));
      end
      tick();
    end

    // credit cap on port 1
    st_valid = 1'b1; st_tag = 10'h000; st_err = 4'h0; s_valid = 4'h0;
    tick();
    st_valid = 1'b0;
    #1;
    chk("clr_counts", 64'(ocount), 0);
    n = 0; s_valid = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (s_ready[1]) n++;
      tick();
    end
    #1;
    chk("cap_accepts", 64'(n), 4);
    chk("cap_ready_low", 64'(s_ready[1]), 0);
    chk("cap_count", 64'(ocount[7:4]), 4);
    st_valid = 1'b1; st_tag = 10'h13C;
    #1;
    chk("cap_ready_during_status", 64'(s_ready[1]), 0);
    tick();
    st_valid = 1'b0;
    #1;
    chk("cap_count_released", 64'(ocount[7:4]), 3);
    chk("cap_ready_back", 64'(s_ready[1]), 1);
    tick();
    s_valid = 4'h0; st_valid = 1'b1; st_tag = 10'h100;
    for (int c = 0; c < 4; c++) tick();
    st_valid = 1'b0;
    tick();
    tick();
    chk("cap_drained", 64'(ocount), 0);
    chk("cap_mvalid_idle", 64'(m_valid), 0);

    // backpressure with scoreboard
    s_valid = 4'b0101; stall_prev = 1'b0; nout = 0; prev_pa = '0; prev_f = '0;
    for (int c = 0; c < 25; c++) begin
      m_ready = !(c < 5 || (c >= 9 && c < 12));
      drive_fields();
      #1;
      acc = s_valid & s_ready;
      for (int i = 0; i < P; i++) if (acc[i]) expq.push_back(model(i, tag_v[i]));
      if (stall_prev) begin
        chk("bp_hold_pa", m_pcie, prev_pa);
        chk("bp_hold_fields", 64'({m_axi, m_len, m_tag}), 64'(prev_f));
      end
      if (m_valid && m_ready) begin
        nout++;
        chk("bp_pending", 64'(expq.size() != 0), 1);
        if (expq.size() != 0) begin
          d = expq.pop_front();
          chk("bp_pa", m_pcie, d.pa);
          chk("bp_fields", 64'({m_axi, m_len, m_tag}), 64'({d.aa, d.ln, d.tg}));
        end
      end
      stall_prev = m_valid && !m_ready;
      prev_pa = m_pcie;
      prev_f = {m_axi, m_len, m_tag};
      tick();
      for (int i = 0; i < P; i++) if (acc[i]) tag_v[i] = tag_v[i] + 8'd1;
    end
    chk("bp_left", 64'(expq.size()), 0);
    chk("bp_nout", 64'(nout), 8);
    chk("bp_counts", 64'(ocount), 64'h0404);

    // reset drops credits, then same-cycle accept and release on port 0
    s_valid = 4'h0; rst_n = 1'b0;
    tick();
    tick();
    chk("rst2_counts", 64'(ocount), 0);
    chk("rst2_mvalid", 64'(m_valid), 0);
    rst_n = 1'b1; m_ready = 1'b1; n = 0; s_valid = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (s_valid[0] && s_ready[0]) n++;
      tick();
      if (n == 3) s_valid = 4'h0;
    end
    chk("same_pre_accepts", 64'(n), 3);
    chk("same_pre_count", 64'(ocount), 3);
    s_valid = 4'b0001; st_valid = 1'b1; st_tag = 10'h0AB; st_err = 4'h0;
    #1;
    chk("same_ready", 64'(s_ready[0]), 1);
    tick();
    s_valid = 4'h0; st_valid = 1'b0;
    #1;
    chk("same_count", 64'(ocount), 3);
    chk("same_stvalid", 64'(ms_valid), 64'h1);
    chk("same_sttag", 64'(ms_tag[7:0]), 64'hAB);

`ifdef PCIE_DMA_DESC_MUX_ERR_CNT_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("err_rst", err_count, 0);
    st_valid = 1'b1; st_tag = 10'h211; st_err = 4'h2;
    for (int c = 0; c < 3; c++) tick();
    st_valid = 1'b0; st_err = 4'h0;
    tick();
    chk("err_count", err_count, 64'h0000_0003_0000_0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
